// File: rtl/mini_alu_ip_sequencer.sv
// rtl/mini_alu_ip_sequencer.sv - MiniAlu instruction pointer sequencer with hardware return stack
module mini_alu_ip_sequencer #(
  parameter int                ADDR_W     = 16,
  parameter int                DEPTH      = 4,
  parameter int                DEPTH_W    = 3,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              iEnable,
  input  logic              iBranch,
  input  logic              iCall,
  input  logic              iRet,
  input  logic [ADDR_W-1:0] iTarget,
  input  logic              iClearErr,
  output logic [ADDR_W-1:0] oIP,
  output logic [DEPTH_W-1:0] oDepth,
  output logic              oFull,
  output logic              oEmpty,
  output logic              oOverflow,
  output logic              oUnderflow
);

  logic [ADDR_W-1:0]  pc;
  logic [ADDR_W-1:0]  stack [DEPTH];
  logic [DEPTH_W-1:0] depth;
  logic               overflow;
  logic               underflow;
  logic [ADDR_W-1:0]  tos;
  logic               full;
  logic               empty;
  logic               do_push;

  assign full  = (depth == DEPTH_W'(DEPTH));
  assign empty = (depth == '0);

  // A CALL only pushes when it is the winning control and there is room.
  assign do_push = iEnable && iCall && !iRet && !full;

  always_comb begin
    tos = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (DEPTH_W'(i) == depth - DEPTH_W'(1)) tos = stack[i];
    end
  end

  always_comb begin
    oIP = pc;
    if (Reset) begin
      oIP = RESET_ADDR;
    end else if (iEnable) begin
      if (iRet) begin
        oIP = empty ? pc : tos;
      end else if (iCall || iBranch) begin
        oIP = iTarget;
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      pc        <= RESET_ADDR;
      depth     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (iEnable) begin
      pc <= oIP + ADDR_W'(1);
      if (iRet) begin
        if (!empty) depth <= depth - DEPTH_W'(1);
      end else if (iCall && !full) begin
        depth <= depth + DEPTH_W'(1);
      end
      // A new error event in the same cycle as a clear leaves the flag set.
      overflow  <= (overflow && !iClearErr) || (iCall && !iRet && full);
      underflow <= (underflow && !iClearErr) || (iRet && empty);
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset && do_push) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (DEPTH_W'(i) == depth) stack[i] <= pc;
      end
    end
  end

  assign oDepth     = depth;
  assign oFull      = full;
  assign oEmpty     = empty;
  assign oOverflow  = overflow;
  assign oUnderflow = underflow;

endmodule
